// File: rtl/sprite_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sprite_pkg : shared state encoding and default geometry for sprite_engine
// Rev 1.0
// ------------------------------------------------------------------
package sprite_pkg;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;
  localparam int CW_DEF    = 3;
  localparam int XW_DEF    = 8;
  localparam int YW_DEF    = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_ERASE  = 3'd2,
    ST_DRAW   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sprite_scan.sv
`default_nettype none
// ------------------------------------------------------------------
// sprite_scan : walks one sprite footprint row-major, one registered slot per step
// Rev 1.0
// ------------------------------------------------------------------
module sprite_scan
  import sprite_pkg::*;
#(
  parameter int SPR_W = 4,
  parameter int SPR_H = 4,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int CW    = CW_DEF,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   fb_ready_i,
  input  logic [XW-1:0]          base_x_i,
  input  logic [YW-1:0]          base_y_i,
  input  logic [CW-1:0]          color_i,
  input  logic [SPR_W*SPR_H-1:0] mask_i,
  output logic [XW-1:0]          x_o,
  output logic [YW-1:0]          y_o,
  output logic [CW-1:0]          color_o,
  output logic                   plot_o,
  output logic                   last_o
);

  localparam int MW  = SPR_W * SPR_H;
  localparam int CCW = $clog2(SPR_W + 1);
  localparam int RCW = $clog2(SPR_H + 1);
  localparam logic [XW:0] X_LIM = (XW + 1)'(H_RES);
  localparam logic [YW:0] Y_LIM = (YW + 1)'(V_RES);

  logic           active_q, active_d;
  logic [CCW-1:0] c_q, c_d;
  logic [RCW-1:0] r_q, r_d;
  logic [XW-1:0]  bx_q, bx_d, x_q, x_d;
  logic [YW-1:0]  by_q, by_d, y_q, y_d;
  logic [CW-1:0]  col_q, col_d, color_q, color_d;
  logic [MW-1:0]  mask_q, mask_d, mshift;
  logic           plot_q, plot_d;
  logic           adv, at_end, load, mbit;
  logic [XW:0]    px;
  logic [YW:0]    py;

  // A pending write (plot=1, no ready) freezes the slot; empty slots always advance.
  assign adv    = active_q && !(plot_q && !fb_ready_i);
  assign at_end = (c_q == CCW'(SPR_W - 1)) && (r_q == RCW'(SPR_H - 1));
  assign last_o = adv && at_end;

  always_comb begin
    active_d = active_q;
    c_d      = c_q;
    r_d      = r_q;
    bx_d     = bx_q;
    by_d     = by_q;
    col_d    = col_q;
    mask_d   = mask_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    plot_d   = plot_q;
    load     = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      c_d      = '0;
      r_d      = '0;
      bx_d     = base_x_i;
      by_d     = base_y_i;
      col_d    = color_i;
      mask_d   = mask_i;
      load     = 1'b1;
    end else if (adv) begin
      if (at_end) begin
        active_d = 1'b0;
        plot_d   = 1'b0;
      end else begin
        load = 1'b1;
        if (c_q == CCW'(SPR_W - 1)) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
    end
    // Extra top bit keeps off-screen coordinates from wrapping back on-screen.
    px     = {1'b0, bx_d} + (XW + 1)'(c_d);
    py     = {1'b0, by_d} + (YW + 1)'(r_d);
    mshift = mask_d >> (int'(r_d) * SPR_W + int'(c_d));
    mbit   = mshift[0];
    if (load) begin
      x_d     = px[XW-1:0];
      y_d     = py[YW-1:0];
      color_d = col_d;
      plot_d  = mbit && (px < X_LIM) && (py < Y_LIM);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      c_q      <= '0;
      r_q      <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      col_q    <= '0;
      mask_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= '0;
      plot_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      c_q      <= c_d;
      r_q      <= r_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      col_q    <= col_d;
      mask_q   <= mask_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      plot_q   <= plot_d;
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign color_o = color_q;
  assign plot_o  = plot_q;

endmodule
`default_nettype wire

// File: rtl/sprite_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// sprite_engine : N-sprite renderer, erases stale footprints then redraws in index order
// Rev 1.0
// ------------------------------------------------------------------
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPR  = 2,
  parameter int SPR_W    = 4,
  parameter int SPR_H    = 4,
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF,
  parameter int CW       = CW_DEF,
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int BG_COLOR = 0
) (
  input  logic                           VGA_CLK,
  input  logic                           resetn,
  input  logic [NUM_SPR*XW-1:0]          spr_x,
  input  logic [NUM_SPR*YW-1:0]          spr_y,
  input  logic [NUM_SPR*CW-1:0]          spr_color,
  input  logic [NUM_SPR-1:0]             spr_en,
  input  logic [NUM_SPR*SPR_W*SPR_H-1:0] spr_mask,
  input  logic                           refresh,
  input  logic                           fb_ready,
  output logic [XW-1:0]                  xvga,
  output logic [YW-1:0]                  yvga,
  output logic [CW-1:0]                  color,
  output logic                           plot,
  output logic                           busy,
  output logic                           done
);

  localparam int MW = SPR_W * SPR_H;
  localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q;
  logic               busy_q, done_q;

  logic [XW-1:0]      in_x [NUM_SPR], x_q [NUM_SPR], sh_x_q [NUM_SPR], cur_x [NUM_SPR];
  logic [YW-1:0]      in_y [NUM_SPR], y_q [NUM_SPR], sh_y_q [NUM_SPR], cur_y [NUM_SPR];
  logic [CW-1:0]      in_col [NUM_SPR], col_q [NUM_SPR], cur_col [NUM_SPR];
  logic [MW-1:0]      in_mask [NUM_SPR], mask_q [NUM_SPR], sh_mask_q [NUM_SPR], cur_mask [NUM_SPR];
  logic [NUM_SPR-1:0] en_q, sh_en_q, cur_en, chg_in, chg_q, cur_chg, erase_set;

  logic               in_latch;
  logic               nxt_found, nxt_erase;
  logic [IW-1:0]      nxt_idx;
  logic               scan_start, scan_last;
  logic [XW-1:0]      sel_x;
  logic [YW-1:0]      sel_y;
  logic [CW-1:0]      sel_col;
  logic [MW-1:0]      sel_mask;

  // During LATCH the working registers are still loading, so read the ports directly.
  assign in_latch = (state_q == ST_LATCH);

  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      in_x[i]     = spr_x[i*XW +: XW];
      in_y[i]     = spr_y[i*YW +: YW];
      in_col[i]   = spr_color[i*CW +: CW];
      in_mask[i]  = spr_mask[i*MW +: MW];
      chg_in[i]   = (in_x[i] != sh_x_q[i]) || (in_y[i] != sh_y_q[i]) ||
                    (spr_en[i] != sh_en_q[i]) || (in_mask[i] != sh_mask_q[i]);
      cur_x[i]    = in_latch ? in_x[i]    : x_q[i];
      cur_y[i]    = in_latch ? in_y[i]    : y_q[i];
      cur_col[i]  = in_latch ? in_col[i]  : col_q[i];
      cur_mask[i] = in_latch ? in_mask[i] : mask_q[i];
    end
    cur_en    = in_latch ? spr_en : en_q;
    cur_chg   = in_latch ? chg_in : chg_q;
    erase_set = cur_chg & sh_en_q;
  end

  // Next sprite job: lowest pending erase first, then lowest pending draw.
  always_comb begin
    nxt_found = 1'b0;
    nxt_erase = 1'b0;
    nxt_idx   = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (cur_en[i] && (state_q != ST_DRAW || i > int'(idx_q))) begin
        nxt_found = 1'b1;
        nxt_erase = 1'b0;
        nxt_idx   = IW'(i);
      end
    end
    if (state_q != ST_DRAW) begin
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
        if (erase_set[i] && (state_q != ST_ERASE || i > int'(idx_q))) begin
          nxt_found = 1'b1;
          nxt_erase = 1'b1;
          nxt_idx   = IW'(i);
        end
      end
    end
    sel_x    = nxt_erase ? sh_x_q[nxt_idx]    : cur_x[nxt_idx];
    sel_y    = nxt_erase ? sh_y_q[nxt_idx]    : cur_y[nxt_idx];
    sel_mask = nxt_erase ? sh_mask_q[nxt_idx] : cur_mask[nxt_idx];
    sel_col  = nxt_erase ? CW'(BG_COLOR)      : cur_col[nxt_idx];
  end

  always_comb begin
    state_d    = state_q;
    scan_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if ((|chg_in) || refresh) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (nxt_found) begin
          scan_start = 1'b1;
          state_d    = nxt_erase ? ST_ERASE : ST_DRAW;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_ERASE, ST_DRAW: begin
        if (scan_last) begin
          if (nxt_found) begin
            scan_start = 1'b1;
            state_d    = nxt_erase ? ST_ERASE : ST_DRAW;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      en_q    <= '0;
      chg_q   <= '0;
      sh_en_q <= '0;
      for (int i = 0; i < NUM_SPR; i++) begin
        x_q[i]       <= '0;
        y_q[i]       <= '0;
        col_q[i]     <= '0;
        mask_q[i]    <= '0;
        sh_x_q[i]    <= '0;
        sh_y_q[i]    <= '0;
        sh_mask_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_FINISH);
      if (scan_start) idx_q <= nxt_idx;
      if (state_q == ST_LATCH) begin
        en_q  <= spr_en;
        chg_q <= chg_in;
        for (int i = 0; i < NUM_SPR; i++) begin
          x_q[i]    <= in_x[i];
          y_q[i]    <= in_y[i];
          col_q[i]  <= in_col[i];
          mask_q[i] <= in_mask[i];
        end
      end
      if (state_q == ST_FINISH) begin
        sh_en_q <= en_q;
        for (int i = 0; i < NUM_SPR; i++) begin
          sh_x_q[i]    <= x_q[i];
          sh_y_q[i]    <= y_q[i];
          sh_mask_q[i] <= mask_q[i];
        end
      end
    end
  end

  sprite_scan #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .XW    (XW),
    .YW    (YW),
    .CW    (CW),
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_scan (
    .clk_i      (VGA_CLK),
    .rst_ni     (resetn),
    .start_i    (scan_start),
    .fb_ready_i (fb_ready),
    .base_x_i   (sel_x),
    .base_y_i   (sel_y),
    .color_i    (sel_col),
    .mask_i     (sel_mask),
    .x_o        (xvga),
    .y_o        (yvga),
    .color_o    (color),
    .plot_o     (plot),
    .last_o     (scan_last)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_sprite_engine : directed and randomized scans against a framebuffer-level model
// Rev 1.0
// ------------------------------------------------------------------
module tb_sprite_engine;

  localparam int N  = 3;
  localparam int SW = 4;
  localparam int SH = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int HR = 160;
  localparam int VR = 120;
  localparam int MW = SW * SH;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [N*XW-1:0]   spr_x = '0;
  logic [N*YW-1:0]   spr_y = '0;
  logic [N*CW-1:0]   spr_color = '0;
  logic [N-1:0]      spr_en = '0;
  logic [N*MW-1:0]   spr_mask = '0;
  logic              refresh = 1'b0;
  logic              fb_ready = 1'b1;
  logic [XW-1:0]     xvga;
  logic [YW-1:0]     yvga;
  logic [CW-1:0]     color;
  logic              plot, busy, done;

  always #5 clk = ~clk;

  sprite_engine #(
    .NUM_SPR(N), .SPR_W(SW), .SPR_H(SH), .XW(XW), .YW(YW), .CW(CW),
    .H_RES(HR), .V_RES(VR), .BG_COLOR(0)
  ) dut (
    .VGA_CLK(clk), .resetn(rstn), .spr_x(spr_x), .spr_y(spr_y),
    .spr_color(spr_color), .spr_en(spr_en), .spr_mask(spr_mask),
    .refresh(refresh), .fb_ready(fb_ready), .xvga(xvga), .yvga(yvga),
    .color(color), .plot(plot), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus values, model shadows and the two framebuffer images.
  int         sx [N], sy [N], sc [N];
  bit         se [N];
  bit [MW-1:0] sm [N];
  int         shx [N], shy [N];
  bit         she [N];
  bit [MW-1:0] shm [N];
  logic [2:0] fb_model [HR][VR];
  logic [2:0] fb_dut   [HR][VR];
  int         exp_q [$];
  int         n_erase, n_draw, first_plot_k;

  function automatic int enc(input int x, input int y, input int c);
    return (x << 10) | (y << 3) | c;
  endfunction

  function automatic bit has_change();
    for (int i = 0; i < N; i++)
      if (sx[i] != shx[i] || sy[i] != shy[i] || se[i] != she[i] || sm[i] != shm[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_footprint(input int x, input int y, input bit [MW-1:0] m, input int c);
    for (int r = 0; r < SH; r++)
      for (int cc = 0; cc < SW; cc++)
        if (m[r*SW+cc] && (x + cc) < HR && (y + r) < VR) exp_q.push_back(enc(x + cc, y + r, c));
  endtask

  task automatic build_exp();
    exp_q.delete();
    n_erase = 0;
    n_draw  = 0;
    for (int i = 0; i < N; i++) begin
      if ((sx[i] != shx[i] || sy[i] != shy[i] || se[i] != she[i] || sm[i] != shm[i]) && she[i]) begin
        n_erase++;
        add_footprint(shx[i], shy[i], shm[i], 0);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (se[i]) begin
        n_draw++;
        add_footprint(sx[i], sy[i], sm[i], sc[i]);
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      spr_x[i*XW +: XW]     = XW'(sx[i]);
      spr_y[i*YW +: YW]     = YW'(sy[i]);
      spr_color[i*CW +: CW] = CW'(sc[i]);
      spr_en[i]             = se[i];
      spr_mask[i*MW +: MW]  = sm[i];
    end
  endtask

  task automatic apply_model(input int count);
    int e;
    for (int j = 0; j < count && j < exp_q.size(); j++) begin
      e = exp_q[j];
      fb_model[e >> 10][(e >> 3) & 127] = 3'(e & 7);
    end
  endtask

  task automatic check_image(input string tag);
    int diffs = 0;
    for (int x = 0; x < HR; x++)
      for (int y = 0; y < VR; y++)
        if (fb_model[x][y] !== fb_dut[x][y]) diffs++;
    check({tag, "/image"}, diffs, 0);
  endtask

  // mode: 0 ready always high, 1 random ready, 2 ready low for three cycles mid-draw.
  // Inputs are applied at the negedge before the call; k counts negedges from there.
  task automatic run_scan(input string tag, input int mode, input int abort_at);
    int k = 0, n_got = 0, busy_low = 0, stalls = 0;
    bit finished = 1'b0, hold = 1'b0;
    logic [18:0] held;
    logic [17:0] w;
    build_exp();
    first_plot_k = -1;
    while (!finished) begin
      @(negedge clk);
      k++;
      refresh = 1'b0;
      if (abort_at != 0 && k == abort_at) begin
        rstn = 1'b0;
        #1;
        check({tag, "/rst_out"}, {plot, busy, done, xvga, yvga, color}, 0);
        apply_model(n_got);
        for (int i = 0; i < N; i++) begin
          shx[i] = 0; shy[i] = 0; she[i] = 1'b0; shm[i] = '0;
        end
        @(negedge clk);
        rstn    = 1'b1;
        refresh = 1'b1;
        return;
      end
      if (hold) check({tag, "/hold"}, {plot, xvga, yvga, color}, held);
      case (mode)
        1:       fb_ready = ($urandom_range(0, 3) != 0);
        2:       fb_ready = !(k >= 22 && k < 25);
        default: fb_ready = 1'b1;
      endcase
      if (plot && first_plot_k < 0) first_plot_k = k;
      if (plot && !fb_ready) stalls++;
      if (plot && fb_ready) begin
        w = {xvga, yvga, color};
        if (n_got < exp_q.size()) check({tag, "/write"}, w, exp_q[n_got]);
        else check({tag, "/extra_write"}, w, 0);
        if (xvga < HR && yvga < VR) fb_dut[xvga][yvga] = color;
        n_got++;
      end
      hold = plot && !fb_ready;
      held = {plot, xvga, yvga, color};
      if (!busy) busy_low++;
      if (done) finished = 1'b1;
      if (k > 4000) begin
        check({tag, "/timeout"}, 1, 0);
        finished = 1'b1;
      end
    end
    check({tag, "/nwrites"}, n_got, exp_q.size());
    check({tag, "/busy"}, busy_low, 0);
    if (mode == 0) check({tag, "/done_cycle"}, k, 2 + MW * (n_erase + n_draw));
    if (mode == 2) check({tag, "/stall_done"}, k, 2 + MW * (n_erase + n_draw) + 3);
    @(negedge clk);
    check({tag, "/done_pulse"}, {busy, done}, 0);
    apply_model(exp_q.size());
    for (int i = 0; i < N; i++) begin
      shx[i] = sx[i]; shy[i] = sy[i]; she[i] = se[i]; shm[i] = sm[i];
    end
    check_image(tag);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      sx[i] = 0; sy[i] = 0; sc[i] = 0; se[i] = 1'b0; sm[i] = '0;
      shx[i] = 0; shy[i] = 0; she[i] = 1'b0; shm[i] = '0;
    end
    for (int x = 0; x < HR; x++)
      for (int y = 0; y < VR; y++) begin
        fb_model[x][y] = '0;
        fb_dut[x][y]   = '0;
      end
    repeat (3) @(negedge clk);
    check("reset", {plot, busy, done, xvga, yvga, color}, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_change", busy, 0);

    sx[0] = 10; sy[0] = 20; sc[0] = 4; se[0] = 1'b1; sm[0] = 16'hFFFF;
    drive();
    run_scan("first_draw", 0, 0);
    check("first_plot_k", first_plot_k, 2);

    sx[0] = 11;
    drive();
    run_scan("move", 0, 0);

    sx[0] = 5; sy[0] = 5; sc[0] = 1;
    sx[1] = 6; sy[1] = 6; sc[1] = 2; se[1] = 1'b1; sm[1] = 16'hFFFF;
    drive();
    run_scan("overlap", 0, 0);
    check("overlap_px", fb_dut[6][6], 2);
    check("overlap_own", fb_dut[5][5], 1);

    refresh = 1'b1;
    run_scan("refresh", 0, 0);

    se[0] = 1'b0; se[1] = 1'b0;
    drive();
    run_scan("disable", 0, 0);

    sx[2] = 158; sy[2] = 118; sc[2] = 5; se[2] = 1'b1; sm[2] = 16'hFFFF;
    drive();
    run_scan("corner", 0, 0);
    check("corner_n", exp_q.size(), 4);

    sx[2] = 40; sy[2] = 30;
    drive();
    run_scan("stall", 2, 0);

    sx[2] = 60; sy[2] = 50;
    drive();
    run_scan("abort", 0, 25);
    run_scan("post_reset", 0, 0);
    check("post_reset_erase", n_erase, 0);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++) begin
        se[i] = 1'($urandom_range(0, 1));
        sx[i] = $urandom_range(0, 170);
        sy[i] = $urandom_range(0, 127);
        sc[i] = $urandom_range(1, 7);
        sm[i] = MW'($urandom);
      end
      drive();
      if (!has_change()) refresh = 1'b1;
      run_scan("random", $urandom_range(0, 1), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
